ibex_mem_responder: RTL

Fixed-latency memory responder for the Ibex instruction or data bus, implementing the device side of the req/gnt/rvalid protocol that the core drives as initiator. It has a word-addressed backing array, configurable response latency, an outstanding-request limit, grant-stall injection, address-range errors, and 7-bit integrity on both write data and read data. It sits opposite `ibex_top` / `ibex_top_tracing` in demo-system simulation and FPGA tops, one instance per bus.

---
 rtl/ibex_mem_resp_pkg.sv | 47 ++++
 rtl/ibex_mem_responder_if.sv | 27 ++
 rtl/ibex_mem_resp_pipe.sv | 39 +++
 rtl/ibex_mem_responder.sv | 97 +++++++++
 4 files changed

// File: rtl/ibex_mem_resp_pkg.sv
// Shared types, limits and the inverted SECDED(39,32) integrity encoder
// for the Ibex memory responder.
package ibex_mem_resp_pkg;

  // Legal parameter ranges of the responder.
  localparam int unsigned LatencyMin     = 1;
  localparam int unsigned LatencyMax     = 4;
  localparam int unsigned OutstandingMin = 1;
  localparam int unsigned OutstandingMax = 4;

  // Width of the in-flight counter; holds 0..LatencyMax.
  localparam int unsigned CntW = 3;

  // Integrity of an all-zero word under the inverted encoding.
  localparam logic [6:0] IntgZero = 7'h2A;

  // One response-pipe stage.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;

  // Inverted Hsiao SECDED(39,32) encoder, bit-compatible with the core's
  // integrity scheme: check bits sit in [38:32] and are XORed with 7'h2A.
  function automatic logic [38:0] secded_inv_39_32_enc(logic [31:0] data);
    logic [38:0] enc;
    enc     = 39'(data);
    enc[32] = ^(enc & 39'h002606BD25);
    enc[33] = ^(enc & 39'h00DEBA8050);
    enc[34] = ^(enc & 39'h00413D89AA);
    enc[35] = ^(enc & 39'h0031234ED1);
    enc[36] = ^(enc & 39'h00C2C1323B);
    enc[37] = ^(enc & 39'h002DCC624C);
    enc[38] = ^(enc & 39'h0098505586);
    enc     = enc ^ 39'h2A00000000;
    return enc;
  endfunction

  // Just the 7 integrity bits of a data word.
  function automatic logic [6:0] intg_of(logic [31:0] data);
    logic [38:0] enc;
    enc = secded_inv_39_32_enc(data);
    return enc[38:32];
  endfunction

endpackage

// File: rtl/ibex_mem_responder_if.sv
// Ibex req/gnt/rvalid bus as seen between the core (master) and the
// memory responder (slave), including the grant-stall test hook.
interface ibex_mem_responder_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [6:0]  wdata_intg;
  logic        stall;
  logic        rvalid;
  logic [31:0] rdata;
  logic [6:0]  rdata_intg;
  logic        err;
  logic        intg_err;

  modport master (
    output req, we, be, addr, wdata, wdata_intg, stall,
    input  gnt, rvalid, rdata, rdata_intg, err, intg_err
  );

  modport slave (
    input  req, we, be, addr, wdata, wdata_intg, stall,
    output gnt, rvalid, rdata, rdata_intg, err, intg_err
  );
endinterface

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-depth response shift pipe. A pushed response leaves the final
// stage exactly Depth cycles later; count reports how many stages hold
// a valid response.
module ibex_mem_resp_pipe
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  mem_resp_t       resp_in,
  output mem_resp_t       resp_out,
  output logic [CntW-1:0] count
);

  mem_resp_t stage_q [Depth];

  // Shift one stage per cycle; bubbles are all-zero so idle outputs read 0.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push ? resp_in : '0;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Number of responses currently in flight.
  always_comb begin
    count = '0;
    for (int i = 0; i < Depth; i++) count = count + CntW'(stage_q[i].valid);
  end

  assign resp_out = stage_q[Depth-1];

endmodule

// File: rtl/ibex_mem_responder.sv
// Fixed-latency memory device for one Ibex instruction or data bus:
// word-addressed array, outstanding-request limit, grant stall hook,
// range errors and write/read data integrity.
module ibex_mem_responder
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned MemDepth       = 4096,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ibex_mem_responder_if.slave bus
);

  localparam int unsigned AddrW = $clog2(MemDepth);

  logic [31:0]      mem [MemDepth];
  logic [AddrW-1:0] word_idx;
  logic             in_range;
  logic             intg_ok;
  logic             pop;
  logic             gnt;
  logic             wr_en;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  in_flight;
  logic             intg_err_q;
  mem_resp_t        resp_in;
  mem_resp_t        resp_out;
  logic             unused_addr;

  assign word_idx    = bus.addr[AddrW+1:2];
  assign in_range    = {2'b00, bus.addr[31:2]} < 32'(MemDepth);
  assign intg_ok     = intg_of(bus.wdata) == bus.wdata_intg;
  assign unused_addr = ^bus.addr[1:0];

  // A response leaving the pipe this cycle frees its slot for a new grant.
  assign pop       = resp_out.valid;
  assign in_flight = count - CntW'(pop);
  assign gnt       = rst_ni & bus.req & ~bus.stall &
                     (in_flight < CntW'(MaxOutstanding));
  assign wr_en     = gnt & bus.we & in_range & intg_ok;

  // Build the response captured into stage 0 at grant.
  // NOTE: every field gets a default first so no path leaves it unassigned
  // (no latch), and blocking assignments are used in combinational logic.
  always_comb begin
    resp_in       = '0;
    resp_in.valid = 1'b1;
    resp_in.err   = ~in_range | (bus.we & ~intg_ok);
    if (!bus.we && in_range) resp_in.rdata = mem[word_idx];
  end

  // Byte-lane writes into the backing array.
  // NOTE: the array is deliberately not reset; contents survive rst_ni and
  // the storage maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be[b]) mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // One-cycle pulse after a granted write whose integrity did not match.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) intg_err_q <= 1'b0;
    else         intg_err_q <= gnt & bus.we & ~intg_ok;
  end

  ibex_mem_resp_pipe #(
    .Depth (ReadLatency)
  ) u_pipe (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (gnt),
    .resp_in  (resp_in),
    .resp_out (resp_out),
    .count    (count)
  );

  assign bus.gnt        = gnt;
  assign bus.rvalid     = resp_out.valid;
  assign bus.rdata      = resp_out.rdata;
  assign bus.err        = resp_out.err;
  assign bus.rdata_intg = intg_of(resp_out.rdata);
  assign bus.intg_err   = intg_err_q;

  // Parameter range checks.
  assert property (@(posedge clk_i)
    (ReadLatency >= LatencyMin) && (ReadLatency <= LatencyMax));
  assert property (@(posedge clk_i)
    (MaxOutstanding >= OutstandingMin) && (MaxOutstanding <= OutstandingMax));
  assert property (@(posedge clk_i)
    (MemDepth >= 2) && ((MemDepth & (MemDepth - 1)) == 0));

endmodule
